// File: rtl/bot_tx_pkg.sv
// Shared types and constants for the bot telemetry/CPU UART transmit arbiter.
package bot_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_X,
        ST_Y,
        ST_INFO,
        ST_SENS,
        ST_CHK
    } tel_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int unsigned PKT_LEN     = 7;
    localparam logic [7:0] CRC_POLY     = 8'h07;

endpackage

// File: rtl/bot_tx_arbiter_crc8.sv
// Combinational byte-wise CRC-8 step (MSB first); used only when BOT_TEL_CRC_EN is defined.
module bot_tel_crc8
    import bot_tx_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    always_comb begin
        logic [7:0] c;
        c = crc_in ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/bot_tx_arbiter.sv
// Shares the uart_tx6 write port between PicoBlaze writes to port 0x0F and a telemetry packet engine.
// Define BOT_TEL_CRC_EN to replace the additive packet checksum with CRC-8 (poly 0x07).
module bot_tx_arbiter
    import bot_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
    parameter bit          RESERVE_HF = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       upd_sysregs,
    input  logic [7:0] locX,
    input  logic [7:0] locY,
    input  logic [7:0] botinfo,
    input  logic [7:0] sensors,
    input  logic       tel_en,
    input  logic [3:0] tel_div,
    input  logic       drop_clr,
    input  logic       buffer_full,
    input  logic       buffer_half_full,
    output logic [7:0] uart_tx_data_in,
    output logic       write_to_uart_tx,
    output logic       tel_busy,
    output logic       cpu_drop,
    output logic [7:0] tel_skip_cnt
);

    tel_state_t state, state_next;

    logic [7:0] seq;
    logic [7:0] snap_x, snap_y, snap_info, snap_sens;
    logic [7:0] chk, chk_next;
    logic [7:0] tel_byte;
    logic [3:0] div_cnt;
    logic       cpu_wr;
    logic       busy;
    logic       trigger;
    logic       tel_grant;
    logic       chk_accum;
    logic       unused_port_bits;

    assign unused_port_bits = ^port_id[7:4];

    assign cpu_wr  = write_strobe && (port_id[3:0] == 4'hF);
    assign busy    = (state != ST_IDLE);
    assign trigger = upd_sysregs && tel_en && (div_cnt == tel_div);
    assign tel_busy = busy;

    // Telemetry only ever takes cycles the CPU leaves unused.
    assign tel_grant = busy && !cpu_wr && !buffer_full && !(RESERVE_HF && buffer_half_full);

`ifdef BOT_TEL_CRC_EN
    bot_tel_crc8 u_crc (
        .crc_in (chk),
        .data   (tel_byte),
        .crc_out(chk_next)
    );
`else
    assign chk_next = chk + tel_byte;
`endif

    always_comb begin
        state_next = state;
        tel_byte   = '0;
        chk_accum  = 1'b0;
        case (state)
            ST_IDLE: if (trigger) state_next = ST_SYNC;
            ST_SYNC: begin
                tel_byte = SYNC_BYTE;
                if (tel_grant) state_next = ST_SEQ;
            end
            ST_SEQ: begin
                tel_byte  = seq;
                chk_accum = 1'b1;
                if (tel_grant) state_next = ST_X;
            end
            ST_X: begin
                tel_byte  = snap_x;
                chk_accum = 1'b1;
                if (tel_grant) state_next = ST_Y;
            end
            ST_Y: begin
                tel_byte  = snap_y;
                chk_accum = 1'b1;
                if (tel_grant) state_next = ST_INFO;
            end
            ST_INFO: begin
                tel_byte  = snap_info;
                chk_accum = 1'b1;
                if (tel_grant) state_next = ST_SENS;
            end
            ST_SENS: begin
                tel_byte  = snap_sens;
                chk_accum = 1'b1;
                if (tel_grant) state_next = ST_CHK;
            end
            ST_CHK: begin
                tel_byte = chk;
                if (tel_grant) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_to_uart_tx <= 1'b0;
            uart_tx_data_in  <= '0;
            cpu_drop         <= 1'b0;
            tel_skip_cnt     <= '0;
            div_cnt          <= '0;
            seq              <= '0;
            snap_x           <= '0;
            snap_y           <= '0;
            snap_info        <= '0;
            snap_sens        <= '0;
            chk              <= '0;
        end else begin
            write_to_uart_tx <= (cpu_wr && !buffer_full) || tel_grant;
            uart_tx_data_in  <= cpu_wr ? out_port : tel_byte;

            if (cpu_wr && buffer_full) begin
                cpu_drop <= 1'b1;
            end else if (drop_clr) begin
                cpu_drop <= 1'b0;
            end

            if (upd_sysregs && tel_en) begin
                div_cnt <= (div_cnt == tel_div) ? 4'd0 : div_cnt + 4'd1;
            end else if (!tel_en) begin
                div_cnt <= '0;
            end

            if (trigger && !busy) begin
                snap_x    <= locX;
                snap_y    <= locY;
                snap_info <= botinfo;
                snap_sens <= sensors;
                chk       <= '0;
            end else if (tel_grant && chk_accum) begin
                chk <= chk_next;
            end

            if (trigger && busy && (tel_skip_cnt != 8'hFF)) begin
                tel_skip_cnt <= tel_skip_cnt + 8'd1;
            end

            if (tel_grant && (state == ST_CHK)) begin
                seq <= seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bot_tx_arbiter.sv
// Scoreboard bench for bot_tx_arbiter: a packet/queue reference model predicts every UART write.
module tb_bot_tx_arbiter;
    import bot_tx_pkg::*;

    localparam bit RESV = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] port_id = '0, out_port = '0;
    logic       write_strobe = 1'b0, upd_sysregs = 1'b0;
    logic [7:0] locX = '0, locY = '0, botinfo = '0, sensors = '0;
    logic       tel_en = 1'b0;
    logic [3:0] tel_div = '0;
    logic       drop_clr = 1'b0, buffer_full = 1'b0, buffer_half_full = 1'b0;
    logic [7:0] uart_tx_data_in;
    logic       write_to_uart_tx, tel_busy, cpu_drop;
    logic [7:0] tel_skip_cnt;

    bot_tx_arbiter #(.SYNC_BYTE(8'hA5), .RESERVE_HF(RESV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .port_id         (port_id),
        .out_port        (out_port),
        .write_strobe    (write_strobe),
        .upd_sysregs     (upd_sysregs),
        .locX            (locX),
        .locY            (locY),
        .botinfo         (botinfo),
        .sensors         (sensors),
        .tel_en          (tel_en),
        .tel_div         (tel_div),
        .drop_clr        (drop_clr),
        .buffer_full     (buffer_full),
        .buffer_half_full(buffer_half_full),
        .uart_tx_data_in (uart_tx_data_in),
        .write_to_uart_tx(write_to_uart_tx),
        .tel_busy        (tel_busy),
        .cpu_drop        (cpu_drop),
        .tel_skip_cnt    (tel_skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] pend[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         dut_pkts = 0;
    logic [7:0] m_seq = '0, m_skip = '0;
    logic [3:0] m_div = '0;
    logic       m_drop = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_chk(input logic [7:0] s, x, y, i, n);
        logic [7:0] b[5];
        logic [7:0] acc;
        b = '{s, x, y, i, n};
        acc = '0;
        for (int k = 0; k < 5; k++) begin
`ifdef BOT_TEL_CRC_EN
            acc = acc ^ b[k];
            for (int j = 0; j < 8; j++) acc = acc[7] ? ((acc << 1) ^ 8'h07) : (acc << 1);
`else
            acc = acc + b[k];
`endif
        end
        return acc;
    endfunction

    // Reference model: one evaluation per rising edge, from the inputs seen at that edge.
    initial begin
        logic cpu, busy, trig;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                expq.delete();
                pend.delete();
                m_seq = '0; m_skip = '0; m_div = '0; m_drop = 1'b0;
            end else begin
                cpu  = write_strobe && (port_id[3:0] == 4'hF);
                busy = pend.size() > 0;
                if (cpu && !buffer_full) begin
                    e.cyc = cyc; e.data = out_port; expq.push_back(e);
                end else if (busy && !cpu && !buffer_full && !(RESV && buffer_half_full)) begin
                    e.cyc = cyc; e.data = pend.pop_front(); expq.push_back(e);
                    if (pend.size() == 0) m_seq = m_seq + 8'd1;
                end
                if (cpu && buffer_full) m_drop = 1'b1;
                else if (drop_clr) m_drop = 1'b0;
                trig = 1'b0;
                if (upd_sysregs && tel_en) begin
                    if (m_div == tel_div) begin m_div = '0; trig = 1'b1; end
                    else m_div = m_div + 4'd1;
                end else if (!tel_en) begin
                    m_div = '0;
                end
                if (trig) begin
                    if (busy) begin
                        if (m_skip != 8'hFF) m_skip = m_skip + 8'd1;
                    end else begin
                        pend.push_back(8'hA5);
                        pend.push_back(m_seq);
                        pend.push_back(locX);
                        pend.push_back(locY);
                        pend.push_back(botinfo);
                        pend.push_back(sensors);
                        pend.push_back(ref_chk(m_seq, locX, locY, botinfo, sensors));
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs 1 time unit after each rising edge.
    initial begin
        logic exp_wr, prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            exp_wr = 1'b0;
            if (expq.size() > 0) begin
                if (expq[0].cyc == cyc) exp_wr = 1'b1;
            end
            check("write_to_uart_tx", {7'd0, write_to_uart_tx}, {7'd0, exp_wr});
            if (exp_wr) begin
                e = expq.pop_front();
                if (write_to_uart_tx) check("uart_tx_data_in", uart_tx_data_in, e.data);
            end
            check("cpu_drop", {7'd0, cpu_drop}, {7'd0, m_drop});
            check("tel_busy", {7'd0, tel_busy}, {7'd0, pend.size() > 0});
            check("tel_skip_cnt", tel_skip_cnt, m_skip);
            if (tel_busy && !prev_busy) dut_pkts++;
            prev_busy = tel_busy;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_upd();
        upd_sysregs = 1'b1; step(1); upd_sysregs = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] d);
        write_strobe = 1'b1; port_id = 8'h0F; out_port = d; step(1); write_strobe = 1'b0;
    endtask

    initial begin
        int p0;
        int waited;
        step(3);
        check("reset_wr", {7'd0, write_to_uart_tx}, 8'd0);
        check("reset_busy", {7'd0, tel_busy}, 8'd0);
        rst_n = 1'b1;
        step(2);

        // Basic packet: A5,00,12,34,05,0F,chk on consecutive cycles.
        tel_en = 1'b1; tel_div = 4'd0;
        locX = 8'h12; locY = 8'h34; botinfo = 8'h05; sensors = 8'h0F;
        pulse_upd(); step(12);

        // CPU write collides with the pending Y byte.
        locX = 8'h21; locY = 8'h43; botinfo = 8'h50; sensors = 8'hF0;
        pulse_upd(); step(3); cpu_write(8'h41); step(12);

        // buffer_full drop, clear, and clear-versus-new-drop.
        buffer_full = 1'b1; cpu_write(8'h55); buffer_full = 1'b0; step(1);
        check("drop_set", {7'd0, cpu_drop}, 8'd1);
        drop_clr = 1'b1; step(1); drop_clr = 1'b0; step(1);
        check("drop_cleared", {7'd0, cpu_drop}, 8'd0);
        buffer_full = 1'b1; drop_clr = 1'b1; cpu_write(8'h66);
        buffer_full = 1'b0; drop_clr = 1'b0; step(1);
        check("drop_wins", {7'd0, cpu_drop}, 8'd1);

        // Reset while the SENS byte is pending, then a fresh packet starting at seq 0.
        pulse_upd(); step(5);
        rst_n = 1'b0; #1;
        check("rst_wr", {7'd0, write_to_uart_tx}, 8'd0);
        check("rst_data", uart_tx_data_in, 8'd0);
        check("rst_busy", {7'd0, tel_busy}, 8'd0);
        check("rst_drop", {7'd0, cpu_drop}, 8'd0);
        check("rst_skip", tel_skip_cnt, 8'd0);
        step(2); rst_n = 1'b1; step(1);
        pulse_upd(); step(12);

        // tel_div=2: six updates give exactly two packets; a trigger mid-packet is skipped.
        tel_div = 4'd2; p0 = dut_pkts;
        repeat (6) begin pulse_upd(); step(11); end
        check("div2_packets", 8'(dut_pkts - p0), 8'd2);
        tel_div = 4'd0; p0 = dut_pkts;
        pulse_upd(); step(2); pulse_upd(); step(12);
        check("skip_cnt", tel_skip_cnt, 8'd1);
        check("skip_packets", 8'(dut_pkts - p0), 8'd1);

        // Half-full holds telemetry back while CPU writes still go through.
        buffer_half_full = 1'b1;
        pulse_upd(); step(3); cpu_write(8'h77); step(4);
        check("hf_stalled", {7'd0, tel_busy}, 8'd1);
        buffer_half_full = 1'b0; step(12);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            write_strobe     = ($urandom % 4) == 0;
            port_id          = 8'($urandom);
            if ($urandom % 2) port_id[3:0] = 4'hF;
            out_port         = 8'($urandom);
            buffer_full      = ($urandom % 8) == 0;
            buffer_half_full = ($urandom % 4) == 0;
            upd_sysregs      = ($urandom % 6) == 0;
            drop_clr         = ($urandom % 10) == 0;
            if ($urandom % 32 == 0) tel_en = ~tel_en;
            if ($urandom % 64 == 0) tel_div = 4'($urandom % 4);
            locX = 8'($urandom); locY = 8'($urandom);
            botinfo = 8'($urandom); sensors = 8'($urandom);
            step(1);
        end

        write_strobe = 1'b0; upd_sysregs = 1'b0; drop_clr = 1'b0;
        buffer_full = 1'b0; buffer_half_full = 1'b0;
        waited = 0;
        while (tel_busy && waited < 200) begin step(1); waited++; end
        check("drain_idle", {7'd0, tel_busy}, 8'd0);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
